// File: rtl/agc_io_pkg.sv
// Shared AGC I/O definitions: channel numbers, keyboard FSM states and
// 16-bit odd-parity helpers (data in [15:1], parity in [0]).
// Also used by the memory and ALU parity paths.
package agc_io_pkg;

  localparam logic [8:0] CH_DSKY_RELAY = 9'o010;
  localparam logic [8:0] CH_LAMPS      = 9'o011;
  localparam logic [8:0] CH_KEYS       = 9'o015;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_DEBOUNCE,
    KEY_PRESSED,
    KEY_RELEASE
  } key_state_t;

  // Parity bit that makes {data, bit} carry an odd number of ones.
  function automatic logic odd_par_gen(input logic [14:0] data);
    return ~^data;
  endfunction

  // True when a full 16-bit channel word has odd total parity.
  function automatic logic odd_par_ok(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Purpose: synchronous key-code FIFO, DEPTH a power of two.
// Latency: push visible at head/empty the cycle after the push edge.
// Backpressure: push while full is refused unless a pop happens on the
//   same edge, in which case both complete.
// Ports: clk, rst_n, push/push_dat, pop, full, empty, head.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A pop on the same edge frees the slot the push is about to fill.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dsky_channel.sv
// Purpose: DSKY I/O-channel responder: relay (010) and lamp (011) writes,
//   keyboard (015) reads, key debounce + queue with KEYRUPT handshake.
// Latency: writes take effect at the sampling edge, disp_update the next
//   cycle; reads registered one cycle; key push DEBOUNCE_CYCLES-1 edges
//   after the first high sample.
// Backpressure: none on the channel; keys pushed into a full queue are
//   dropped and flagged in sticky key_overflow.
// Ports: clk/rst_n; ch_addr/ch_wr/ch_rd/ch_wdata/ch_rdata channel bus;
//   key_valid/key_code raw keyboard; keyrupt_req/keyrupt_ack handshake;
//   disp_update/disp_row/disp_bits relay; lamps; parity_err; key_overflow.
module dsky_channel
  import agc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,  // must be >= 2
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  ch_addr,
  input  logic        ch_wr,
  input  logic        ch_rd,
  input  logic [15:0] ch_wdata,
  output logic [15:0] ch_rdata,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        keyrupt_req,
  input  logic        keyrupt_ack,
  output logic        disp_update,
  output logic [3:0]  disp_row,
  output logic [10:0] disp_bits,
  output logic [14:0] lamps,
  output logic        parity_err,
  output logic        key_overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------- write path ----------------
  logic        wr_par_ok;
  logic        wr_ok;
  logic [3:0]  wr_row;
  logic        relay_ok;
  logic [10:0] row_reg [16];

  assign wr_par_ok = odd_par_ok(ch_wdata);
  assign wr_ok     = ch_wr && wr_par_ok;
  assign wr_row    = ch_wdata[15:12];
  assign relay_ok  = wr_ok && (ch_addr == CH_DSKY_RELAY) &&
                     (wr_row >= 4'd1) && (wr_row <= 4'd12);

  // Rows 0 and 13-15 are never written and stay 0, so after reset the
  // lookup yields 0; afterwards it yields the last accepted relay word.
  assign disp_bits = row_reg[disp_row];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) row_reg[i] <= '0;
      disp_row    <= '0;
      disp_update <= 1'b0;
      lamps       <= '0;
      parity_err  <= 1'b0;
    end else begin
      disp_update <= relay_ok;
      if (ch_wr && !wr_par_ok) parity_err <= 1'b1;
      if (relay_ok) begin
        row_reg[wr_row] <= ch_wdata[11:1];
        disp_row        <= wr_row;
      end
      if (wr_ok && (ch_addr == CH_LAMPS)) lamps <= ch_wdata[15:1];
    end
  end

  // ---------------- key queue ----------------
  logic       q_push;
  logic       q_full;
  logic       q_empty;
  logic [4:0] q_head;
  logic [4:0] latched;

  key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(5)) u_key_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_dat (latched),
    .pop      (keyrupt_ack),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  assign keyrupt_req = !q_empty;

  // ---------------- read path ----------------
  logic [14:0] key_word;
  assign key_word = {10'b0, (q_empty ? 5'd0 : q_head)};

  // Sampled before this edge's writes, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_rdata <= 16'h0000;
    end else if (ch_rd) begin
      case (ch_addr)
        CH_KEYS:  ch_rdata <= {key_word, odd_par_gen(key_word)};
        CH_LAMPS: ch_rdata <= {lamps, odd_par_gen(lamps)};
        default:  ch_rdata <= 16'h0001;
      endcase
    end
  end

  // ---------------- keyboard debounce FSM ----------------
  key_state_t      state;
  logic [CW-1:0]   cnt;
  logic            stable;

  assign stable = key_valid && (key_code == latched);
  // The push lands on the edge that completes the stable run, which keeps
  // the press latency at DEBOUNCE_CYCLES-1 edges after the first sample.
  assign q_push = (state == KEY_DEBOUNCE) && stable && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= KEY_IDLE;
      cnt          <= '0;
      latched      <= '0;
      key_overflow <= 1'b0;
    end else begin
      if (q_push && q_full && !keyrupt_ack) key_overflow <= 1'b1;
      case (state)
        KEY_IDLE: begin
          if (key_valid && (key_code != 5'd0)) begin
            latched <= key_code;
            cnt     <= CW'(1);
            state   <= KEY_DEBOUNCE;
          end
        end
        KEY_DEBOUNCE: begin
          if (!stable)                state <= KEY_IDLE;
          else if (cnt == CNT_LAST)   state <= KEY_PRESSED;
          else                        cnt   <= cnt + 1'b1;
        end
        KEY_PRESSED: begin
          // Held key never re-pushes; only a full release re-arms IDLE.
          if (!key_valid) begin
            cnt   <= CW'(1);
            state <= KEY_RELEASE;
          end
        end
        KEY_RELEASE: begin
          if (key_valid)              state <= KEY_PRESSED;
          else if (cnt == CNT_LAST)   state <= KEY_IDLE;
          else                        cnt   <= cnt + 1'b1;
        end
        default: state <= KEY_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsky_channel.sv
// Directed bench for dsky_channel: relay/lamp writes, parity, reads,
// key debounce, queue overflow/drain and asynchronous reset.
module tb_dsky_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  ch_addr = '0;
  logic        ch_wr = 1'b0;
  logic        ch_rd = 1'b0;
  logic [15:0] ch_wdata = '0;
  logic [15:0] ch_rdata;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic        keyrupt_req;
  logic        keyrupt_ack = 1'b0;
  logic        disp_update;
  logic [3:0]  disp_row;
  logic [10:0] disp_bits;
  logic [14:0] lamps;
  logic        parity_err;
  logic        key_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsky_channel #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_addr      (ch_addr),
    .ch_wr        (ch_wr),
    .ch_rd        (ch_rd),
    .ch_wdata     (ch_wdata),
    .ch_rdata     (ch_rdata),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .keyrupt_req  (keyrupt_req),
    .keyrupt_ack  (keyrupt_ack),
    .disp_update  (disp_update),
    .disp_row     (disp_row),
    .disp_bits    (disp_bits),
    .lamps        (lamps),
    .parity_err   (parity_err),
    .key_overflow (key_overflow)
  );

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ch_wr = 1'b0; ch_rd = 1'b0; key_valid = 1'b0; key_code = '0; keyrupt_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge right after the write edge.
  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    ch_addr = a; ch_wdata = d; ch_wr = 1'b1;
    @(negedge clk);
    ch_wr = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, output logic [15:0] d);
    @(negedge clk);
    ch_addr = a; ch_rd = 1'b1;
    @(negedge clk);
    ch_rd = 1'b0;
    d = ch_rdata;
  endtask

  task automatic do_ack();
    @(negedge clk);
    keyrupt_ack = 1'b1;
    @(negedge clk);
    keyrupt_ack = 1'b0;
  endtask

  task automatic press(input logic [4:0] code, input int hold, input int low);
    @(negedge clk);
    key_valid = 1'b1; key_code = code;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    key_valid = 1'b0; key_code = '0;
    repeat (low) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ch_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", ch_rdata); end
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", keyrupt_req); end
    checks++; if ({disp_update, disp_row, disp_bits} !== 16'h0) begin failures++; $display("FAIL reset_disp got=%b/%h/%h exp=0", disp_update, disp_row, disp_bits); end
    checks++; if (lamps !== 15'h0) begin failures++; $display("FAIL reset_lamps got=%h exp=0", lamps); end
    checks++; if ({parity_err, key_overflow} !== 2'b00) begin failures++; $display("FAIL reset_sticky got=%b exp=00", {parity_err, key_overflow}); end
  endtask

  task automatic test_relay_write();
    do_write(9'o010, 16'hB547);
    checks++; if (disp_update !== 1'b1) begin failures++; $display("FAIL relay_pulse got=%b exp=1", disp_update); end
    checks++; if (disp_row !== 4'd11) begin failures++; $display("FAIL relay_row got=%0d exp=11", disp_row); end
    checks++; if (disp_bits !== 11'b01010100011) begin failures++; $display("FAIL relay_bits got=%b exp=01010100011", disp_bits); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL relay_perr got=%b exp=0", parity_err); end
    @(negedge clk);
    checks++; if (disp_update !== 1'b0) begin failures++; $display("FAIL relay_pulse_width got=%b exp=0", disp_update); end
    // Row 0 and row 13: ignored, no pulse.
    do_write(9'o010, 16'h0001);
    checks++; if ({disp_update, disp_row} !== {1'b0, 4'd11}) begin failures++; $display("FAIL relay_row0 got=%b/%0d exp=0/11", disp_update, disp_row); end
    do_write(9'o010, 16'hD000);
    checks++; if ({disp_update, disp_row} !== {1'b0, 4'd11}) begin failures++; $display("FAIL relay_row13 got=%b/%0d exp=0/11", disp_update, disp_row); end
    do_write(9'o010, 16'h3FFE);
    checks++; if ({disp_update, disp_row, disp_bits} !== {1'b1, 4'd3, 11'h7FF}) begin failures++; $display("FAIL relay_row3 got=%b/%0d/%h exp=1/3/7ff", disp_update, disp_row, disp_bits); end
    do_write(9'o010, 16'hB547);
  endtask

  task automatic test_parity();
    do_write(9'o010, 16'hB546);
    checks++; if (disp_update !== 1'b0) begin failures++; $display("FAIL perr_pulse got=%b exp=0", disp_update); end
    checks++; if ({disp_row, disp_bits} !== {4'd11, 11'b01010100011}) begin failures++; $display("FAIL perr_row_kept got=%0d/%b exp=11/01010100011", disp_row, disp_bits); end
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", parity_err); end
    // Even-parity lamp write is dropped too.
    do_write(9'o011, 16'h8001);
    checks++; if (lamps !== 15'h0) begin failures++; $display("FAIL perr_lamp_drop got=%h exp=0", lamps); end
  endtask

  task automatic test_lamps_read();
    logic [15:0] rd;
    do_write(9'o011, 16'hAAAB);
    checks++; if (lamps !== 15'h5555) begin failures++; $display("FAIL lamps_write got=%h exp=5555", lamps); end
    do_read(9'o011, rd);
    checks++; if (rd !== 16'hAAAB) begin failures++; $display("FAIL lamps_read got=%h exp=aaab", rd); end
    do_read(9'o012, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL other_read got=%h exp=0001", rd); end
    // Simultaneous read and write: read shows the old lamp word.
    @(negedge clk);
    ch_addr = 9'o011; ch_wdata = 16'h8000; ch_wr = 1'b1; ch_rd = 1'b1;
    @(negedge clk);
    ch_wr = 1'b0; ch_rd = 1'b0;
    checks++; if (ch_rdata !== 16'hAAAB) begin failures++; $display("FAIL rdwr_old got=%h exp=aaab", ch_rdata); end
    checks++; if (lamps !== 15'h4000) begin failures++; $display("FAIL rdwr_new got=%h exp=4000", lamps); end
    repeat (2) @(negedge clk);
    checks++; if (ch_rdata !== 16'hAAAB) begin failures++; $display("FAIL rdata_hold got=%h exp=aaab", ch_rdata); end
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", parity_err); end
  endtask

  task automatic test_key_press();
    logic [15:0] rd;
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'b10001;
    repeat (3) @(negedge clk);
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL press_early got=%b exp=0", keyrupt_req); end
    @(negedge clk);
    checks++; if (keyrupt_req !== 1'b1) begin failures++; $display("FAIL press_latency got=%b exp=1", keyrupt_req); end
    repeat (2) @(negedge clk);
    key_valid = 1'b0; key_code = '0;
    repeat (6) @(negedge clk);
    do_read(9'o015, rd);
    checks++; if (rd !== 16'h0023) begin failures++; $display("FAIL press_read got=%h exp=0023", rd); end
    do_ack();
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL press_ack got=%b exp=0", keyrupt_req); end
    do_read(9'o015, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL press_empty_read got=%h exp=0001", rd); end
  endtask

  task automatic test_glitch_bounce();
    logic [15:0] rd;
    press(5'b00111, 2, 6);
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL glitch_req got=%b exp=0", keyrupt_req); end
    // Held 6, 3-cycle bounce low, held 4 more, then a real release.
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'b00111;
    repeat (6) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    key_valid = 1'b1;
    repeat (4) @(negedge clk);
    key_valid = 1'b0; key_code = '0;
    repeat (6) @(negedge clk);
    do_read(9'o015, rd);
    checks++; if (rd !== 16'h000E) begin failures++; $display("FAIL bounce_read got=%h exp=000e", rd); end
    do_ack();
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL bounce_single_push got=%b exp=0", keyrupt_req); end
  endtask

  task automatic test_overflow();
    logic [15:0] rd;
    logic [15:0] exp_q [4];
    exp_q = '{16'h0002, 16'h0004, 16'h0007, 16'h0008};
    do_reset();
    for (int i = 1; i <= 4; i++) press(5'(i), 6, 6);
    checks++; if ({keyrupt_req, key_overflow} !== 2'b10) begin failures++; $display("FAIL ovf_four got=%b exp=10", {keyrupt_req, key_overflow}); end
    press(5'd5, 6, 6);
    checks++; if (key_overflow !== 1'b1) begin failures++; $display("FAIL ovf_fifth got=%b exp=1", key_overflow); end
    for (int i = 0; i < 4; i++) begin
      do_read(9'o015, rd);
      checks++; if (rd !== exp_q[i]) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd, exp_q[i]); end
      do_ack();
    end
    checks++; if ({keyrupt_req, key_overflow} !== 2'b01) begin failures++; $display("FAIL ovf_drained got=%b exp=01", {keyrupt_req, key_overflow}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    logic [15:0] exp_q [4];
    exp_q = '{16'h0004, 16'h0007, 16'h0008, 16'h000B};
    do_reset();
    for (int i = 1; i <= 4; i++) press(5'(i), 6, 6);
    // Fifth press with ack landing on the push edge.
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'd5;
    repeat (3) @(negedge clk);
    keyrupt_ack = 1'b1;
    @(negedge clk);
    keyrupt_ack = 1'b0;
    checks++; if ({keyrupt_req, key_overflow} !== 2'b10) begin failures++; $display("FAIL b2b_no_ovf got=%b exp=10", {keyrupt_req, key_overflow}); end
    repeat (2) @(negedge clk);
    key_valid = 1'b0; key_code = '0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_read(9'o015, rd);
      checks++; if (rd !== exp_q[i]) begin failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, rd, exp_q[i]); end
      do_ack();
    end
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", keyrupt_req); end
    do_ack();  // ack on empty queue
    press(5'd6, 6, 6);
    do_read(9'o015, rd);
    checks++; if (rd !== 16'h000D) begin failures++; $display("FAIL empty_ack_noop got=%h exp=000d", rd); end
    do_ack();
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL empty_ack_req got=%b exp=0", keyrupt_req); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    press(5'd6, 6, 6);
    press(5'd7, 6, 6);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'd9;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (keyrupt_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%b exp=0", keyrupt_req); end
    checks++; if (ch_rdata !== 16'h0000) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=0000", ch_rdata); end
    key_valid = 1'b0; key_code = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_read(9'o015, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL rst_mid_read got=%h exp=0001", rd); end
    checks++; if ({keyrupt_req, key_overflow} !== 2'b00) begin failures++; $display("FAIL rst_mid_state got=%b exp=00", {keyrupt_req, key_overflow}); end
  endtask

  initial begin
    test_reset();
    test_relay_write();
    test_parity();
    test_lamps_read();
    test_key_press();
    test_glitch_bounce();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
